// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Pure declarations; no latency and no flow control of its own.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int REG_W       = 4;
  localparam int INSTR_W     = 16;
  localparam int HALT_DRAIN  = 3;
  localparam int DRAIN_CNT_W = 2;
  localparam int STALL_CNT_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // Register 0 is hard-wired, so a write to it never feeds a later reader.
  function automatic logic reg_match(input logic [REG_W-1:0] src,
                                     input logic             used,
                                     input logic [REG_W-1:0] dst);
    return used && (src == dst) && (dst != '0);
  endfunction

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use compare between the ID source fields and the EX load destination.
// Purely combinational, zero latency; no flow control.
module hazard_lu_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs_ID,
  input  logic [REG_W-1:0] rt_ID,
  input  logic             rs_used_ID,
  input  logic             rt_used_ID,
  input  logic             ld_EX,
  input  logic             we_EX,
  input  logic [REG_W-1:0] rd_EX,
  output logic             lu_hazard
);

  assign lu_hazard = ld_EX && we_EX &&
                     (reg_match(rs_ID, rs_used_ID, rd_EX) ||
                      reg_match(rt_ID, rt_used_ID, rd_EX));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze > branch > load-use > halt priority, outputs same-cycle combinational.
// mem_busy freezes the whole pipe and holds all state; optional stall counter under HAZ_STALL_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_W-1:0]       rs_ID,
  input  logic [REG_W-1:0]       rt_ID,
  input  logic                   rs_used_ID,
  input  logic                   rt_used_ID,
  input  logic                   ld_EX,
  input  logic                   we_EX,
  input  logic [REG_W-1:0]       rd_EX,
  input  logic                   br_taken_EX,
  input  logic                   halt_ID,
  input  logic                   mem_busy,
  output logic                   pc_we,
  output logic                   stall_IF_ID,
  output logic                   flush_IF_ID,
  output logic                   bubble_ID_EX,
  output logic                   freeze,
`ifdef HAZ_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
  output logic                   halted
);

  state_t                 state, state_nxt;
  logic [DRAIN_CNT_W-1:0] cnt, cnt_nxt;
  logic                   lu_hazard;

  hazard_lu_detect u_lu_detect (
    .rs_ID      (rs_ID),
    .rt_ID      (rt_ID),
    .rs_used_ID (rs_used_ID),
    .rt_used_ID (rt_used_ID),
    .ld_EX      (ld_EX),
    .we_EX      (we_EX),
    .rd_EX      (rd_EX),
    .lu_hazard  (lu_hazard)
  );

  always_comb begin
    pc_we        = 1'b0;
    stall_IF_ID  = 1'b0;
    flush_IF_ID  = 1'b0;
    bubble_ID_EX = 1'b0;
    freeze       = 1'b0;
    halted       = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    // Outputs are forced low while reset is held so the PC cannot move.
    if (rst_n) begin
      halted = (state == HALTED);
      if (mem_busy) begin
        freeze      = 1'b1;
        stall_IF_ID = 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (br_taken_EX) begin
              pc_we        = 1'b1;
              flush_IF_ID  = 1'b1;
              bubble_ID_EX = 1'b1;
            end else if (lu_hazard) begin
              stall_IF_ID  = 1'b1;
              bubble_ID_EX = 1'b1;
            end else if (halt_ID) begin
              flush_IF_ID = 1'b1;
              state_nxt   = DRAIN;
              cnt_nxt     = DRAIN_CNT_W'(HALT_DRAIN);
            end else begin
              pc_we = 1'b1;
            end
          end
          DRAIN: begin
            flush_IF_ID = 1'b1;
            // The cycle that takes the counter to zero is the last drain cycle.
            if (cnt <= 2'd1) begin
              cnt_nxt   = '0;
              state_nxt = HALTED;
            end else begin
              cnt_nxt = cnt - 2'd1;
            end
          end
          HALTED: begin
            stall_IF_ID = 1'b1;
            freeze      = 1'b1;
          end
          default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!pc_we && (state != HALTED) && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level behavioural model; stall counter covered under HAZ_STALL_CNT_EN.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [3:0] rs_ID = '0, rt_ID = '0, rd_EX = '0;
  logic       rs_used_ID = 1'b0, rt_used_ID = 1'b0, ld_EX = 1'b0, we_EX = 1'b0;
  logic       br_taken_EX = 1'b0, halt_ID = 1'b0, mem_busy = 1'b0;
  logic       pc_we, stall_IF_ID, flush_IF_ID, bubble_ID_EX, freeze, halted;
`ifdef HAZ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  hazard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs_ID        (rs_ID),
    .rt_ID        (rt_ID),
    .rs_used_ID   (rs_used_ID),
    .rt_used_ID   (rt_used_ID),
    .ld_EX        (ld_EX),
    .we_EX        (we_EX),
    .rd_EX        (rd_EX),
    .br_taken_EX  (br_taken_EX),
    .halt_ID      (halt_ID),
    .mem_busy     (mem_busy),
    .pc_we        (pc_we),
    .stall_IF_ID  (stall_IF_ID),
    .flush_IF_ID  (flush_IF_ID),
    .bubble_ID_EX (bubble_ID_EX),
    .freeze       (freeze),
`ifdef HAZ_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .halted       (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=running, 1=draining, 2=halted; drain progress counted upward.
  int m_mode = 0, m_drained = 0, m_stalls = 0;
  int nx_mode, nx_drained, nx_stalls;

  always @(negedge clk) begin
    bit e_pc, e_st, e_fl, e_bu, e_fr, e_ha, hz;
    e_pc = 0; e_st = 0; e_fl = 0; e_bu = 0; e_fr = 0; e_ha = 0;
    nx_mode = m_mode; nx_drained = m_drained; nx_stalls = m_stalls;
    hz = ld_EX && we_EX && (rd_EX != 0) &&
         ((rs_used_ID && rs_ID == rd_EX) || (rt_used_ID && rt_ID == rd_EX));
    if (!rst_n) begin
      nx_mode = 0; nx_drained = 0; nx_stalls = 0;
    end else begin
      e_ha = (m_mode == 2);
      if (mem_busy) begin
        e_fr = 1; e_st = 1;
      end else if (m_mode == 2) begin
        e_st = 1; e_fr = 1;
      end else if (m_mode == 1) begin
        e_fl = 1;
        nx_drained = m_drained + 1;
        if (nx_drained == 3) nx_mode = 2;
      end else if (br_taken_EX) begin
        e_pc = 1; e_fl = 1; e_bu = 1;
      end else if (hz) begin
        e_st = 1; e_bu = 1;
      end else if (halt_ID) begin
        e_fl = 1; nx_mode = 1; nx_drained = 0;
      end else begin
        e_pc = 1;
      end
      if (!e_pc && m_mode != 2 && m_stalls < 65535) nx_stalls = m_stalls + 1;
    end
    chk("model_pc_we", 32'(pc_we), 32'(e_pc));
    chk("model_stall_IF_ID", 32'(stall_IF_ID), 32'(e_st));
    chk("model_flush_IF_ID", 32'(flush_IF_ID), 32'(e_fl));
    chk("model_bubble_ID_EX", 32'(bubble_ID_EX), 32'(e_bu));
    chk("model_freeze", 32'(freeze), 32'(e_fr));
    chk("model_halted", 32'(halted), 32'(e_ha));
`ifdef HAZ_STALL_CNT_EN
    chk("model_stall_cnt", 32'(stall_cnt), 32'(m_stalls));
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_drained = 0; m_stalls = 0;
    end else begin
      m_mode = nx_mode; m_drained = nx_drained; m_stalls = nx_stalls;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_ID = '0; rt_ID = '0; rd_EX = '0;
    rs_used_ID = 0; rt_used_ID = 0; ld_EX = 0; we_EX = 0;
    br_taken_EX = 0; halt_ID = 0; mem_busy = 0;
  endtask

  task automatic lu_vec(input string name, input logic [3:0] rs, input logic [3:0] rt,
                        input logic rsu, input logic rtu, input logic ld, input logic we,
                        input logic [3:0] rd, input logic exp_stall);
    tick();
    idle();
    rs_ID = rs; rt_ID = rt; rs_used_ID = rsu; rt_used_ID = rtu;
    ld_EX = ld; we_EX = we; rd_EX = rd;
    @(negedge clk);
    chk(name, 32'(stall_IF_ID), 32'(exp_stall));
    chk(name, 32'(pc_we), 32'(!exp_stall));
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(negedge clk);
    chk("rst_pc_we", 32'(pc_we), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    tick();
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("idle_pc_we", 32'(pc_we), 32'd1);

    // Basic load-use on rs, released when the load leaves EX.
    tick();
    ld_EX = 1; we_EX = 1; rd_EX = 4'd5; rs_ID = 4'd5; rs_used_ID = 1;
    @(negedge clk);
    chk("lu_pc_we", 32'(pc_we), 32'd0);
    chk("lu_stall", 32'(stall_IF_ID), 32'd1);
    chk("lu_bubble", 32'(bubble_ID_EX), 32'd1);
    tick();
    ld_EX = 0;
    @(negedge clk);
    chk("lu_release_pc_we", 32'(pc_we), 32'd1);

    lu_vec("lu_rd_zero",    4'd0, 4'd0, 1, 0, 1, 1, 4'd0, 0);
    lu_vec("lu_rs_zero_rd", 4'd5, 4'd0, 1, 0, 1, 1, 4'd0, 0);
    lu_vec("lu_rs_unused",  4'd5, 4'd0, 0, 0, 1, 1, 4'd5, 0);
    lu_vec("lu_rt_match",   4'd0, 4'd7, 0, 1, 1, 1, 4'd7, 1);
    lu_vec("lu_no_we",      4'd7, 4'd3, 1, 1, 1, 0, 4'd7, 0);
    lu_vec("lu_no_ld",      4'd7, 4'd3, 1, 1, 0, 1, 4'd7, 0);
    lu_vec("lu_rt_only",    4'd9, 4'd3, 1, 1, 1, 1, 4'd3, 1);

    // Branch wins over a simultaneous load-use hazard.
    tick();
    idle();
    ld_EX = 1; we_EX = 1; rd_EX = 4'd5; rs_ID = 4'd5; rs_used_ID = 1; br_taken_EX = 1;
    @(negedge clk);
    chk("br_lu_flush", 32'(flush_IF_ID), 32'd1);
    chk("br_lu_bubble", 32'(bubble_ID_EX), 32'd1);
    chk("br_lu_pc_we", 32'(pc_we), 32'd1);
    chk("br_lu_stall", 32'(stall_IF_ID), 32'd0);

    // Freeze masks a branch; the flush appears once memory is ready.
    tick();
    idle();
    mem_busy = 1; br_taken_EX = 1;
    @(negedge clk);
    chk("frz_br_freeze", 32'(freeze), 32'd1);
    chk("frz_br_flush", 32'(flush_IF_ID), 32'd0);
    tick();
    mem_busy = 0;
    @(negedge clk);
    chk("frz_br_after_flush", 32'(flush_IF_ID), 32'd1);
    chk("frz_br_after_freeze", 32'(freeze), 32'd0);

    // Halt at c0, drain c1..c5 with c2,c3 frozen, halted from c6.
    tick();
    idle();
    halt_ID = 1;
    @(negedge clk);
    chk("halt_c0_flush", 32'(flush_IF_ID), 32'd1);
    chk("halt_c0_pc_we", 32'(pc_we), 32'd0);
    tick();
    halt_ID = 0;
    @(negedge clk);
    chk("halt_c1_halted", 32'(halted), 32'd0);
    tick();
    mem_busy = 1;
    tick();
    @(negedge clk);
    chk("halt_c3_freeze", 32'(freeze), 32'd1);
    chk("halt_c3_flush", 32'(flush_IF_ID), 32'd0);
    tick();
    mem_busy = 0;
    tick();
    @(negedge clk);
    chk("halt_c5_halted", 32'(halted), 32'd0);
    chk("halt_c5_flush", 32'(flush_IF_ID), 32'd1);
    tick();
    @(negedge clk);
    chk("halt_c6_halted", 32'(halted), 32'd1);
    chk("halt_c6_pc_we", 32'(pc_we), 32'd0);
    tick();
    mem_busy = 1;
    @(negedge clk);
    chk("halt_busy_halted", 32'(halted), 32'd1);
    tick();
    mem_busy = 0;
    br_taken_EX = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("halt_hold_halted", 32'(halted), 32'd1);
    chk("halt_hold_pc_we", 32'(pc_we), 32'd0);

    tick();
    idle();
    rst_n = 0;
    @(negedge clk);
    chk("halt_rst_halted", 32'(halted), 32'd0);
    chk("halt_rst_stall", 32'(stall_IF_ID), 32'd0);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_pc_we", 32'(pc_we), 32'd1);
    chk("post_rst_halted", 32'(halted), 32'd0);

`ifdef HAZ_STALL_CNT_EN
    chk("cnt_start", 32'(stall_cnt), 32'd0);
    tick();
    ld_EX = 1; we_EX = 1; rd_EX = 4'd5; rs_ID = 4'd5; rs_used_ID = 1;
    repeat (70000) tick();
    @(negedge clk);
    chk("cnt_saturated", 32'(stall_cnt), 32'h0000FFFF);
    tick();
    idle();
    rst_n = 0;
    @(negedge clk);
    chk("cnt_reset", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1;
`endif

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
